// File: rtl/sram_sp_bwe_pwr.sv
// Single-port SRAM model/wrapper with per-bit write enables, power-state
// machine (ACTIVE/SLEEP/SHUTDOWN/WAKE), optional read output register and a
// sticky access-violation flag.
// Define SRAM_BIST_EN to route the *M port set onto the array when BIST=1.
module sram_sp_bwe_pwr #(
    parameter int DW       = 32,
    parameter int AW       = 11,
    parameter int WAKE_CYC = 4,
    parameter int OUT_REG  = 0
) (
    input  logic          CLK,
    input  logic          RSTB,
    input  logic          SLP,
    input  logic          SD,
    input  logic          CEB,
    input  logic          WEB,
    input  logic [AW-1:0] A,
    input  logic [DW-1:0] D,
    input  logic [DW-1:0] BWEB,
    input  logic          BIST,
    input  logic          CEBM,
    input  logic          WEBM,
    input  logic [AW-1:0] AM,
    input  logic [DW-1:0] DM,
    input  logic [DW-1:0] BWEBM,
    output logic [DW-1:0] Q,
    output logic          QV,
    output logic          RDY,
    output logic          ERR
);

    localparam int DEPTH = 2 ** AW;

    typedef enum logic [1:0] {
        ST_ACTIVE   = 2'd0,
        ST_SLEEP    = 2'd1,
        ST_SHUTDOWN = 2'd2,
        ST_WAKE     = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [DW-1:0] q_q, q_d;
    logic          qv_q, qv_d;
    logic          rdy_q, rdy_d;
    logic          err_q, err_d;
    logic [DW-1:0] stg_data_q, stg_data_d;
    logic          stg_vld_q, stg_vld_d;

    logic [DW-1:0] mem_q [DEPTH];

    // effective array controls
    logic          ce, we;
    logic [AW-1:0] a;
    logic [DW-1:0] d, bweb;

    logic          rd, wr, wipe;
    logic [DW-1:0] rd_data;

`ifdef SRAM_BIST_EN
    // Select the BIST port set or the functional port set ahead of sampling
    always_comb begin
        ce   = BIST ? CEBM  : CEB;
        we   = BIST ? WEBM  : WEB;
        a    = BIST ? AM    : A;
        d    = BIST ? DM    : D;
        bweb = BIST ? BWEBM : BWEB;
    end
`else
    // Functional ports drive the array directly; BIST inputs are dropped
    always_comb begin
        ce   = CEB;
        we   = WEB;
        a    = A;
        d    = D;
        bweb = BWEB;
    end

    logic unused_bist;
    assign unused_bist = ^{BIST, CEBM, WEBM, AM, DM, BWEBM};
`endif

    // State register and all control/output flops
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!RSTB) begin
            state_q    <= ST_ACTIVE;
            cnt_q      <= '0;
            q_q        <= '0;
            qv_q       <= 1'b0;
            rdy_q      <= 1'b1;
            err_q      <= 1'b0;
            stg_data_q <= '0;
            stg_vld_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            q_q        <= q_d;
            qv_q       <= qv_d;
            rdy_q      <= rdy_d;
            err_q      <= err_d;
            stg_data_q <= stg_data_d;
            stg_vld_q  <= stg_vld_d;
        end
    end

    // Next power state and wake counter; any exit from WAKE clears the count
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        state_d = state_q;
        cnt_d   = '0;
        unique case (state_q)
            ST_ACTIVE: begin
                if (SD)       state_d = ST_SHUTDOWN;
                else if (SLP) state_d = ST_SLEEP;
            end
            ST_SLEEP: begin
                if (SD)       state_d = ST_SHUTDOWN;
                else if (!SLP) state_d = ST_WAKE;
            end
            ST_SHUTDOWN: begin
                if (!SD)      state_d = SLP ? ST_SLEEP : ST_WAKE;
            end
            ST_WAKE: begin
                if (SD)       state_d = ST_SHUTDOWN;
                else if (SLP) state_d = ST_SLEEP;
                else if (cnt_q == 8'(WAKE_CYC - 1)) state_d = ST_ACTIVE;
                else          cnt_d = cnt_q + 8'd1;
            end
            default: state_d = ST_ACTIVE;
        endcase
    end

    // Access decode, violation flag, read pipeline and registered RDY
    always_comb begin
        rd      = RSTB && !ce && (state_q == ST_ACTIVE) && we;
        wr      = RSTB && !ce && (state_q == ST_ACTIVE) && !we;
        wipe    = RSTB && (state_d == ST_SHUTDOWN) && (state_q != ST_SHUTDOWN);
        rd_data = mem_q[a];

        err_d   = err_q | (!ce && (state_q != ST_ACTIVE));
        rdy_d   = (state_d == ST_ACTIVE);

        stg_vld_d  = rd && (OUT_REG != 0);
        stg_data_d = rd ? rd_data : stg_data_q;

        if (OUT_REG != 0) begin
            qv_d = stg_vld_q;
            q_d  = stg_vld_q ? stg_data_q : q_q;
        end else begin
            qv_d = rd;
            q_d  = rd ? rd_data : q_q;
        end
    end

    // Array: bit-masked write, or full clear on entry to SHUTDOWN
    always_ff @(posedge CLK) begin
        // NOTE: the array has no reset; only SHUTDOWN entry clears it, as the hard macro would lose contents.
        if (wipe) begin
            for (int i = 0; i < DEPTH; i++) mem_q[AW'(i)] <= '0;
        end else if (wr) begin
            mem_q[a] <= (mem_q[a] & bweb) | (d & ~bweb);
        end
    end

    assign Q   = q_q;
    assign QV  = qv_q;
    assign RDY = rdy_q;
    assign ERR = err_q;

endmodule

// File: tb/tb_sram_sp_bwe_pwr.sv
// Scoreboard bench for sram_sp_bwe_pwr: reads push expected data into a
// queue, a negedge monitor pops and compares whenever QV pulses.
module tb_sram_sp_bwe_pwr;

    localparam int DW       = 32;
    localparam int AW       = 11;
    localparam int WAKE_CYC = 4;
    localparam int OUT_REG  = 0;
    localparam int LAT      = (OUT_REG != 0) ? 2 : 1;

    logic          clk;
    logic          RSTB, SLP, SD, CEB, WEB, BIST, CEBM, WEBM;
    logic [AW-1:0] A, AM;
    logic [DW-1:0] D, BWEB, DM, BWEBM;
    logic [DW-1:0] Q;
    logic          QV, RDY, ERR;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   n_edges;

    sram_sp_bwe_pwr #(
        .DW(DW), .AW(AW), .WAKE_CYC(WAKE_CYC), .OUT_REG(OUT_REG)
    ) dut (
        .CLK(clk), .RSTB(RSTB), .SLP(SLP), .SD(SD),
        .CEB(CEB), .WEB(WEB), .A(A), .D(D), .BWEB(BWEB),
        .BIST(BIST), .CEBM(CEBM), .WEBM(WEBM), .AM(AM), .DM(DM), .BWEBM(BWEBM),
        .Q(Q), .QV(QV), .RDY(RDY), .ERR(ERR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every QV pulse must match the oldest outstanding read
    always @(negedge clk) begin
        exp_t e;
        if (QV === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_qv: got QV=1 Q=0x%0h, expected no read completion", Q);
            end else begin
                e = exp_q.pop_front();
                check("read_q", 64'(Q), 64'(e.data));
                check("read_latency", 64'(cyc - e.cyc), 64'(LAT));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] bw);
        CEB = 1'b0; WEB = 1'b0; A = a; D = d; BWEB = bw;
        tick();
        CEB = 1'b1; WEB = 1'b1;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] expd);
        CEB = 1'b0; WEB = 1'b1; A = a;
        exp_q.push_back('{data: expd, cyc: cyc});
        tick();
        CEB = 1'b1;
    endtask

    // Ticks until RDY rises, bounded; returns the number of edges taken
    task automatic wake_count(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!RDY && n < 40);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        RSTB = 1'b0; SLP = 1'b0; SD = 1'b0;
        CEB = 1'b1; WEB = 1'b1; A = '0; D = '0; BWEB = '1;
        BIST = 1'b0; CEBM = 1'b1; WEBM = 1'b1; AM = '0; DM = '0; BWEBM = '1;

        // reset state
        tick(); tick();
        check("reset_q",   64'(Q),   64'h0);
        check("reset_qv",  64'(QV),  64'h0);
        check("reset_rdy", 64'(RDY), 64'h1);
        check("reset_err", 64'(ERR), 64'h0);
        RSTB = 1'b1;
        tick();

        // full write and read back
        do_write(11'h005, 32'hDEADBEEF, 32'h0);
        do_read(11'h005, 32'hDEADBEEF);

        // bit-masked writes
        do_write(11'h010, 32'hFFFFFFFF, 32'h0);
        do_write(11'h010, 32'h00000000, 32'hFFFF00FF);
        do_read(11'h010, 32'hFFFF00FF);
        do_write(11'h011, 32'h00000000, 32'h0);
        do_write(11'h011, 32'h89ABCDEF, 32'h0000FFFF);
        do_read(11'h011, 32'h89AB0000);

        // light sleep for 10 cycles, contents retained
        SLP = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("sleep_rdy", 64'(RDY), 64'h0);
        end
        SLP = 1'b0;
        wake_count(n_edges);
        check("sleep_wake_edges", 64'(n_edges), 64'(WAKE_CYC + 1));
        check("sleep_err", 64'(ERR), 64'h0);
        do_read(11'h005, 32'hDEADBEEF);
        do_read(11'h010, 32'hFFFF00FF);

        // abort WAKE at count 2 with SLP, then the full count restarts
        SLP = 1'b1; tick();
        SLP = 1'b0; tick(); tick(); tick();
        check("wake_mid_rdy", 64'(RDY), 64'h0);
        SLP = 1'b1; tick();
        check("wake_abort_rdy", 64'(RDY), 64'h0);
        SLP = 1'b0;
        wake_count(n_edges);
        check("wake_restart_edges", 64'(n_edges), 64'(WAKE_CYC + 1));

        // write sampled on the edge SLP rises is still performed
        SLP = 1'b1;
        do_write(11'h020, 32'hCAFEF00D, 32'h0);
        check("slp_edge_rdy", 64'(RDY), 64'h0);
        SLP = 1'b0;
        wake_count(n_edges);
        check("slp_edge_wake_edges", 64'(n_edges), 64'(WAKE_CYC + 1));
        do_read(11'h020, 32'hCAFEF00D);
        check("slp_edge_err", 64'(ERR), 64'h0);

        // BIST port: only effective when the mux is built in
        do_write(11'h7FF, 32'hA5A5A5A5, 32'h0);
        BIST = 1'b1; CEBM = 1'b0; WEBM = 1'b0; AM = 11'h7FF; DM = 32'h12345678; BWEBM = 32'h0;
        tick();
        BIST = 1'b0; CEBM = 1'b1; WEBM = 1'b1;
`ifdef SRAM_BIST_EN
        do_read(11'h7FF, 32'h12345678);
`else
        do_read(11'h7FF, 32'hA5A5A5A5);
`endif

        // shutdown: read on the SD edge completes, contents then lost
        SD = 1'b1;
        do_read(11'h005, 32'hDEADBEEF);
        check("sd_rdy", 64'(RDY), 64'h0);
        SD = 1'b0;
        tick();
        CEB = 1'b0; WEB = 1'b1; A = 11'h005;
        tick();
        CEB = 1'b1;
        check("wake_access_err", 64'(ERR), 64'h1);
        check("wake_access_rdy", 64'(RDY), 64'h0);
        wake_count(n_edges);
        check("sd_wake_edges", 64'(n_edges), 64'(WAKE_CYC + 1 - 2));
        do_read(11'h005, 32'h0);
        do_read(11'h010, 32'h0);
        tick(); tick();
        check("err_sticky", 64'(ERR), 64'h1);

        // reset clears the sticky flag
        repeat (LAT + 1) tick();
        RSTB = 1'b0;
        tick();
        check("rst2_err", 64'(ERR), 64'h0);
        check("rst2_rdy", 64'(RDY), 64'h1);
        check("rst2_q",   64'(Q),   64'h0);
        RSTB = 1'b1;
        tick();

        repeat (LAT + 2) tick();
        check("queue_empty", 64'(exp_q.size()), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
